alu_exec_unit: RTL and testbench

ALU_EXEC_UNIT -- requirements
Module: alu_exec_unit

---
 rtl/alu_exec_unit.sv | 125 ++++++++++++
 tb/tb_alu_exec_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit. Single-cycle operations finish in one cycle.
// Shifts take one cycle per bit position, so a shift by N occupies the unit for N + 1 cycles.
module alu_exec_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_control,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             illegal
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLL  = 4'b0110;
    localparam logic [3:0] OP_SRL  = 4'b0111;
    localparam logic [3:0] OP_SRA  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    logic [1:0]       state;
    logic [3:0]       op;
    logic [WIDTH-1:0] shift_data;
    logic [WIDTH-1:0] shift_next;
    logic [4:0]       count;
    logic [4:0]       shamt;
    logic [WIDTH-1:0] alu_value;
    logic             alu_illegal;
    logic             is_shift;

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign shamt     = src_b[4:0];
    assign is_shift  = (alu_control == OP_SLL) || (alu_control == OP_SRL) ||
                       (alu_control == OP_SRA);

    // Result of a request taken this cycle; a shift by zero simply passes src_a through.
    always_comb begin
        alu_value   = '0;
        alu_illegal = 1'b0;
        case (alu_control)
            OP_ADD:  alu_value = src_a + src_b;
            OP_SUB:  alu_value = src_a - src_b;
            OP_AND:  alu_value = src_a & src_b;
            OP_OR:   alu_value = src_a | src_b;
            OP_XOR:  alu_value = src_a ^ src_b;
            OP_SLT:  alu_value = {{(WIDTH-1){1'b0}}, ($signed(src_a) < $signed(src_b))};
            OP_SLTU: alu_value = {{(WIDTH-1){1'b0}}, (src_a < src_b)};
            OP_SLL, OP_SRL, OP_SRA: alu_value = src_a;
            default: alu_illegal = 1'b1;
        endcase
    end

    // One-bit step of the shift in progress; sra keeps replicating the original sign bit.
    always_comb begin
        shift_next = shift_data;
        case (op)
            OP_SLL:  shift_next = {shift_data[WIDTH-2:0], 1'b0};
            OP_SRL:  shift_next = {1'b0, shift_data[WIDTH-1:1]};
            OP_SRA:  shift_next = {shift_data[WIDTH-1], shift_data[WIDTH-1:1]};
            default: shift_next = shift_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            op         <= '0;
            shift_data <= '0;
            count      <= '0;
            result     <= '0;
            zero       <= 1'b0;
            illegal    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        if (is_shift && (shamt != 5'd0)) begin
                            op         <= alu_control;
                            shift_data <= src_a;
                            count      <= shamt;
                            state      <= SHIFT;
                        end else begin
                            result  <= alu_value;
                            zero    <= (alu_value == '0);
                            illegal <= alu_illegal;
                            state   <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    shift_data <= shift_next;
                    count      <= count - 5'd1;
                    if (count == 5'd1) begin
                        result  <= shift_next;
                        zero    <= (shift_next == '0);
                        illegal <= 1'b0;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: the stimulus thread queues hand-computed results,
// and a monitor pops and checks them on every output handshake.
module tb_alu_exec_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [3:0]  alu_control = 4'd0;
    logic [31:0] src_a = '0;
    logic [31:0] src_b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        illegal;

    typedef struct packed {
        logic [31:0] res;
        logic        z;
        logic        ill;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    alu_exec_unit #(.WIDTH(32)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .alu_control(alu_control), .src_a(src_a), .src_b(src_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, actual, expected);
        end
    endtask

    // Monitor: every output handshake must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checkOutput("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                checkOutput("sb_result", result, e.res);
                checkOutput("sb_zero", {31'd0, zero}, {31'd0, e.z});
                checkOutput("sb_illegal", {31'd0, illegal}, {31'd0, e.ill});
            end
        end
    end

    task automatic applyStimulus(input string name, input logic [3:0] op,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] exp_res, input logic exp_ill,
                                 input int exp_lat, input int hold);
        int   lat;
        int   ready_seen;
        exp_t e;
        lat = 0;
        while (!in_ready && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({name, "_in_ready"}, {31'd0, in_ready}, 32'd1);
        alu_control = op;
        src_a       = a;
        src_b       = b;
        in_valid    = 1'b1;
        e.res = exp_res;
        e.z   = (exp_res == 32'd0);
        e.ill = exp_ill;
        sb.push_back(e);
        @(posedge clk); #1;
        in_valid    = 1'b0;
        alu_control = 4'b0001;
        src_a       = 32'hDEAD_BEEF;
        src_b       = 32'h1234_5671;
        lat         = 1;
        ready_seen  = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_seen++;
            @(posedge clk); #1;
            lat++;
        end
        if (in_ready) ready_seen++;
        checkOutput({name, "_latency"}, lat, exp_lat);
        checkOutput({name, "_busy_ready"}, ready_seen, 32'd0);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            checkOutput({name, "_hold_valid"}, {31'd0, out_valid}, 32'd1);
            checkOutput({name, "_hold_result"}, result, exp_res);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({name, "_idle_after"}, {31'd0, in_ready}, 32'd1);
        checkOutput({name, "_valid_after"}, {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int idle_valid;
        $display("[TB] start");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("reset_result", result, 32'd0);
        checkOutput("reset_zero", {31'd0, zero}, 32'd0);
        checkOutput("reset_illegal", {31'd0, illegal}, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("ready_after_reset", {31'd0, in_ready}, 32'd1);

        applyStimulus("add",      4'b0000, 32'd5,          32'd7,          32'd12,         1'b0, 1,  0);
        applyStimulus("sub_zero", 4'b0001, 32'd3,          32'd3,          32'd0,          1'b0, 1,  0);
        applyStimulus("slt",      4'b0101, 32'hFFFF_FFFF,  32'd1,          32'd1,          1'b0, 1,  0);
        applyStimulus("sltu",     4'b1001, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1,  0);
        applyStimulus("sra",      4'b1000, 32'h8000_0000,  32'd4,          32'hF800_0000,  1'b0, 5,  0);
        applyStimulus("srl",      4'b0111, 32'h8000_0000,  32'd4,          32'h0800_0000,  1'b0, 5,  0);
        applyStimulus("xor_bp",   4'b0100, 32'hF0F0_F0F0,  32'hFFFF_FFFF,  32'h0F0F_0F0F,  1'b0, 1,  3);
        applyStimulus("illegal",  4'b1100, 32'd9,          32'd4,          32'd0,          1'b1, 1,  0);
        applyStimulus("ill_1111", 4'b1111, 32'd1,          32'd1,          32'd0,          1'b1, 1,  0);
        applyStimulus("and",      4'b0010, 32'hFF00_FF00,  32'h0F0F_0F0F,  32'h0F00_0F00,  1'b0, 1,  0);
        applyStimulus("or",       4'b0011, 32'hA000_0005,  32'h0500_0050,  32'hA500_0055,  1'b0, 1,  0);
        applyStimulus("add_wrap", 4'b0000, 32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0, 1,  0);
        applyStimulus("sub_wrap", 4'b0001, 32'd0,          32'd1,          32'hFFFF_FFFF,  1'b0, 1,  0);
        applyStimulus("sll_0",    4'b0110, 32'h1234_5678,  32'hFFFF_FFE0,  32'h1234_5678,  1'b0, 1,  0);
        applyStimulus("sll_31",   4'b0110, 32'd1,          32'd31,         32'h8000_0000,  1'b0, 32, 0);
        applyStimulus("sra_pos",  4'b1000, 32'h4000_0000,  32'd3,          32'h0800_0000,  1'b0, 4,  1);

        // Reset during the third shift cycle must abort with nothing delivered.
        alu_control = 4'b0110;
        src_a       = 32'd1;
        src_b       = 32'd31;
        in_valid    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        checkOutput("abort_out_valid", {31'd0, out_valid}, 32'd0);
        checkOutput("abort_result", result, 32'd0);
        checkOutput("abort_in_ready", {31'd0, in_ready}, 32'd1);
        idle_valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) idle_valid++;
        end
        checkOutput("abort_no_result", idle_valid, 32'd0);

        checkOutput("sb_drained", sb.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
